// File: rtl/alu_reg_if.sv
// alu_reg_if: operand/opcode request and registered result bundle for alu_reg
interface alu_reg_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       aluop;
    logic             in_valid;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             overflow;
    logic             out_valid;
    modport master (output a, b, aluop, in_valid, input c, zero, overflow, out_valid);
    modport slave (input a, b, aluop, in_valid, output c, zero, overflow, out_valid);
endinterface

// File: rtl/alu_reg.sv
// alu_reg: six-op ALU with a single registered result/flag stage
module alu_reg #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    alu_reg_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] r;
    logic             ovf;
    assign sh = bus.b[SW-1:0];
    // kept out of the ternary chain so the shift stays in signed context
    assign sra = $signed(bus.a) >>> sh;
    always_comb begin
        r = bus.aluop == 3'b000 ? bus.a + bus.b :
            bus.aluop == 3'b001 ? bus.a - bus.b :
            bus.aluop == 3'b010 ? bus.a & bus.b :
            bus.aluop == 3'b011 ? bus.a | bus.b :
            bus.aluop == 3'b100 ? bus.a >> sh :
            bus.aluop == 3'b101 ? sra : '0;
        ovf = (bus.aluop == 3'b000 && bus.a[WIDTH-1] == bus.b[WIDTH-1] && r[WIDTH-1] != bus.a[WIDTH-1]) ||
              (bus.aluop == 3'b001 && bus.a[WIDTH-1] != bus.b[WIDTH-1] && r[WIDTH-1] != bus.a[WIDTH-1]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.c         <= '0;
            bus.zero      <= 1'b1;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.c        <= r;
                bus.zero     <= r == '0;
                bus.overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_alu_reg.sv
// tb_alu_reg: directed vectors, reset/hold sequences and randomized model check for alu_reg
module tb_alu_reg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    alu_reg_if #(.WIDTH(32)) bus ();
    alu_reg #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        z;
        logic        v;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [31:0] c, input logic z, input logic v, input logic ov);
        chk({n, ".c"}, bus.c, c);
        chk({n, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
        chk({n, ".overflow"}, {31'd0, bus.overflow}, {31'd0, v});
        chk({n, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic iv);
        bus.aluop = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = iv;
    endtask

    // reference from arithmetic on wide signed values rather than bit-level flag rules
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s = 0;
        int n = int'(b % 32);
        v = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; r = 32'(s); v = s != longint'($signed(r)); end
            3'd1: begin s = sa - sb; r = 32'(s); v = s != longint'($signed(r)); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a >> n;
            3'd5: r = 32'(sa >>> n);
            default: r = 32'd0;
        endcase
    endfunction

    vec_t vecs[$];
    logic [31:0] exp_c;
    logic        exp_z;
    logic        exp_v;
    logic [31:0] r;
    logic        v;
    logic        iv;
    logic [31:0] edge_vals[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h21};

    initial begin
        vecs = '{
            '{3'b000, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0},
            '{3'b001, 32'd2, 32'd1, 32'd1, 1'b0, 1'b0},
            '{3'b010, 32'd2, 32'd1, 32'd0, 1'b1, 1'b0},
            '{3'b011, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0},
            '{3'b100, 32'd2, 32'd1, 32'd1, 1'b0, 1'b0},
            '{3'b101, 32'd2, 32'd1, 32'd1, 1'b0, 1'b0},
            '{3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1},
            '{3'b110, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0},
            '{3'b001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0},
            '{3'b100, 32'h80000010, 32'd4, 32'h08000001, 1'b0, 1'b0},
            '{3'b101, 32'h80000010, 32'd4, 32'hF8000001, 1'b0, 1'b0},
            '{3'b100, 32'h80000010, 32'd33, 32'h40000008, 1'b0, 1'b0},
            '{3'b101, 32'h80000010, 32'd33, 32'hC0000008, 1'b0, 1'b0},
            '{3'b101, 32'h80000010, 32'd0, 32'h80000010, 1'b0, 1'b0},
            '{3'b100, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0},
            '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0},
            '{3'b001, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0}
        };
        drive(3'b011, 32'hDEADBEEF, 32'h1234, 1'b1);
        #3 reset = 1'b1;
        #1 chk_all("reset_async", 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("reset_held", 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].z, vecs[i].v, 1'b1);
        end

        drive(3'b000, 32'h7FFFFFFF, 32'd1, 1'b1);
        step();
        drive(3'bxxx, 32'hxxxxxxxx, 32'hxxxxxxxx, 1'b0);
        step();
        chk_all("hold1", 32'h80000000, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("hold2", 32'h80000000, 1'b0, 1'b1, 1'b0);

        drive(3'b000, 32'd10, 32'd20, 1'b1);
        step();
        chk_all("pre_reset", 32'd30, 1'b0, 1'b0, 1'b1);
        drive(3'b011, 32'hF0, 32'h0F, 1'b1);
        #2 reset = 1'b1;
        #1 chk_all("mid_reset", 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("mid_reset_edge", 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        chk_all("after_release", 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("first_after_reset", 32'hFF, 1'b0, 1'b0, 1'b1);

        exp_c = 32'hFF;
        exp_z = 1'b0;
        exp_v = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            iv = $urandom_range(3) != 0;
            bus.aluop = 3'($urandom_range(7));
            bus.a = $urandom_range(3) == 0 ? edge_vals[$urandom_range(5)] : $urandom;
            bus.b = $urandom_range(3) == 0 ? edge_vals[$urandom_range(5)] : $urandom;
            if (!iv && $urandom_range(1) == 1) begin
                bus.a = 32'hxxxxxxxx;
                bus.aluop = 3'bxxx;
            end
            bus.in_valid = iv;
            if (iv) begin
                model(bus.aluop, bus.a, bus.b, r, v);
                exp_c = r;
                exp_z = r == 32'd0;
                exp_v = v;
            end
            step();
            chk_all($sformatf("rand%0d", k), exp_c, exp_z, exp_v, iv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit combinational ALU core with a registered result stage.
- Computes one of six arithmetic/logic/shift operations on A and B, selected by a 3-bit opcode.
- Result and status flags are captured on the clock edge.
- Sits in the datapath execute stage; downstream logic reads C one cycle after operands and opcode are presented.

Parameters:
- WIDTH, 32, operand and result width. Behaviour is defined for 32; shift amount uses the low log2(WIDTH) bits of B.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- A  input  32  operand A
- B  input  32  operand B (shift amount for shift ops)
- ALUOp  input  3  operation select
- in_valid  input  1  operands/opcode valid this cycle
- C  output  32  registered result
- zero  output  1  registered flag: C == 0
- overflow  output  1  registered signed-overflow flag (add/sub only)
- out_valid  output  1  C/zero/overflow correspond to an accepted request

Behaviour:
Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Ports are named clk and reset.
- While reset is high, and immediately on its assertion: C=0, zero=1, overflow=0, out_valid=0.
- Reset asserted mid-operation discards any in-flight result.

Opcode encoding (combinational result R):
- 000 ADD: R = A + B, modulo 2^32; carry-out discarded.
- 001 SUB: R = A - B, modulo 2^32.
- 010 AND: R = A & B.
- 011 OR: R = A | B.
- 100 SRL: R = A >> B[4:0], logical, zero fill.
- 101 SRA: R = A >>> B[4:0], arithmetic, sign fill from A[31].
- 110, 111 reserved: R = 0, overflow = 0.
- Shift ops ignore B[31:5]; shift by 0 returns A unchanged.

Overflow (computed combinationally, 0 for all non-ADD/SUB opcodes):
- ADD: set when A[31]==B[31] and R[31]!=A[31].
- SUB: set when A[31]!=B[31] and R[31]!=A[31].

Register stage, on each rising clk edge with reset low:
- If in_valid=1: C<=R, zero<=(R==0), overflow<=ovf, out_valid<=1.
- If in_valid=0: C, zero and overflow hold their values; out_valid<=0.

Timing:
- Latency is exactly 1 cycle; throughput is one operation per cycle; there is no backpressure.
- An ALUOp or operand change between edges has no effect on outputs until the next edge.
- Inputs that are X or undriven while in_valid=0 must not disturb outputs.

Test Plan:
- Reset: assert reset with arbitrary inputs -> C=0, zero=1, overflow=0, out_valid=0 immediately, without a clock edge.
- A=2, B=1, in_valid=1, ALUOp stepped 000..101 one per cycle -> C=3, 1, 0, 3, 1, 1 on successive cycles; zero=1 only for AND; overflow=0 throughout; out_valid=1.
- Overflow: ADD with A=0x7FFFFFFF, B=1 -> C=0x80000000, overflow=1. SUB with A=0x80000000, B=1 -> C=0x7FFFFFFF, overflow=1. ADD with A=0xFFFFFFFF, B=1 -> C=0, zero=1, overflow=0.
- Shifts: A=0x80000010 with B=4 -> SRL gives 0x08000001, SRA gives 0xF8000001. B=33 behaves as shift by 1. B=0 returns A.
- Reserved and hold: ALUOp=110/111 -> C=0, zero=1. Drop in_valid -> C holds its last value and out_valid=0 next cycle.
- Reset mid-stream: assert reset between two valid ops -> outputs clear asynchronously; the first valid op after deassertion produces its result one cycle later.
